// File: rtl/ctrl_pkg.sv
// Shared encodings for the ctrl_pipe control path: ALU ops, condition codes,
// instruction class fields, flag indices and the pipelined control bundles.
package ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'ha;
    localparam logic [3:0] COND_LT = 4'hb;
    localparam logic [3:0] COND_GT = 4'hc;
    localparam logic [3:0] COND_LE = 4'hd;
    localparam logic [3:0] COND_AL = 4'he;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // An all-zero ctl_e_t is a bubble: no enable set, no flag update.
    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flag_write;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       pcs;
        logic       alu_src;
        logic       ig_rn;
        logic [3:0] alu_ctl;
    } ctl_e_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic pcs;
    } ctl_m_t;

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[FLG_N];
        z = flags[FLG_Z];
        c = flags[FLG_C];
        v = flags[FLG_V];
        case (cond)
            COND_EQ: cond_holds = z;
            COND_NE: cond_holds = ~z;
            COND_CS: cond_holds = c;
            COND_CC: cond_holds = ~c;
            COND_MI: cond_holds = n;
            COND_PL: cond_holds = ~n;
            COND_VS: cond_holds = v;
            COND_VC: cond_holds = ~v;
            COND_HI: cond_holds = c & ~z;
            COND_LS: cond_holds = ~c | z;
            COND_GE: cond_holds = (n == v);
            COND_LT: cond_holds = (n != v);
            COND_GT: cond_holds = ~z & (n == v);
            COND_LE: cond_holds = z | (n != v);
            COND_AL: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_pipe_cond_unit.sv
// Execute-stage condition unit: owns the NZCV register, evaluates the E-stage
// condition against the pre-update flags and gates the side-effecting enables.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [1:0] flag_write,
    input  logic [3:0] alu_flags,
    input  logic       reg_write,
    input  logic       mem_write,
    input  logic       pcs,
    input  logic       branch,
    output logic       cond_ex,
    output logic       reg_write_g,
    output logic       mem_write_g,
    output logic       pcs_g,
    output logic       branch_taken
);

    logic [3:0] flags_q;

    assign cond_ex      = cond_holds(cond, flags_q);
    assign reg_write_g  = reg_write & cond_ex;
    assign mem_write_g  = mem_write & cond_ex;
    assign pcs_g        = pcs & cond_ex;
    assign branch_taken = branch & cond_ex;

    // NZ and CV are written independently so logical ops keep the carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            if (cond_ex && flag_write[1]) begin
                flags_q[FLG_N:FLG_Z] <= alu_flags[FLG_N:FLG_Z];
            end
            if (cond_ex && flag_write[0]) begin
                flags_q[FLG_C:FLG_V] <= alu_flags[FLG_C:FLG_V];
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control path for the 5-stage core: decode in D, condition check in E, D->W in 3 cycles.
// Only FlushE bubbles E; E->M->W never stall. CTRL_STATS_EN adds retired/squash counters.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         InstrD,
    input  logic [3:0]          ALUFlags,
    input  logic                FlushE,
    output logic [1:0]          RegSrcD,
    output logic [1:0]          ImmSrcD,
    output logic                ALUSrcE,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic                IgRnE,
    output logic                BranchTakenE,
    output logic                MemWriteM,
    output logic                RegWriteM,
    output logic                MemtoRegE,
    output logic                RegWriteW,
    output logic                MemtoRegW,
    output logic                PCSrcW,
    output logic                PCWrPendingF
`ifdef CTRL_STATS_EN
    ,
    output logic [31:0]         RetiredCnt,
    output logic [31:0]         SquashCnt
`endif
);

    ctl_e_t dec;
    ctl_e_t ctl_e;
    ctl_m_t ctl_m;
    ctl_m_t ctl_m_next;
    logic   dp_known;
    logic   dp_arith;
    logic   cond_ex_e;
    logic   reg_write_w;
    logic   mem_to_reg_w;
    logic   pcs_w;
    logic   unused_bits;

    // Register numbers and offsets belong to the datapath.
    assign unused_bits = ^{InstrD[19:16], InstrD[11:0]};

    always_comb begin
        dec      = '0;
        RegSrcD  = 2'b00;
        ImmSrcD  = 2'b00;
        dp_known = 1'b0;
        dp_arith = 1'b0;
        dec.cond = InstrD[31:28];
        case (InstrD[27:26])
            OP_DP: begin
                dec.alu_src = InstrD[25];
                dp_known    = 1'b1;
                case (InstrD[24:21])
                    CMD_ADD: begin dec.alu_ctl = ALU_ADD; dp_arith = 1'b1; end
                    CMD_SUB: begin dec.alu_ctl = ALU_SUB; dp_arith = 1'b1; end
                    CMD_AND: dec.alu_ctl = ALU_AND;
                    CMD_ORR: dec.alu_ctl = ALU_ORR;
                    CMD_MOV: begin dec.alu_ctl = ALU_ADD; dec.ig_rn = 1'b1; end
                    CMD_CMP: begin dec.alu_ctl = ALU_SUB; dp_arith = 1'b1; end
                    default: dp_known = 1'b0;
                endcase
                dec.reg_write = dp_known && (InstrD[24:21] != CMD_CMP);
                if (InstrD[24:21] == CMD_CMP) begin
                    dec.flag_write = 2'b11;
                end else if (InstrD[20]) begin
                    dec.flag_write = {dp_known, dp_arith};
                end
            end
            OP_MEM: begin
                dec.alu_src = 1'b1;
                dec.alu_ctl = ALU_ADD;
                ImmSrcD     = 2'b01;
                if (InstrD[20]) begin
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = 1'b1;
                end else begin
                    dec.mem_write = 1'b1;
                    RegSrcD       = 2'b10;
                end
            end
            OP_BR: begin
                dec.branch  = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_ctl = ALU_ADD;
                ImmSrcD     = 2'b10;
                RegSrcD     = 2'b01;
            end
            default: ;
        endcase
        dec.pcs = dec.reg_write && (InstrD[15:12] == 4'hf);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_e <= '0;
        end else if (FlushE) begin
            ctl_e <= '0;
        end else begin
            ctl_e <= dec;
        end
    end

    cond_unit u_cond (
        .clk          (clk),
        .rst_n        (reset),
        .cond         (ctl_e.cond),
        .flag_write   (ctl_e.flag_write),
        .alu_flags    (ALUFlags),
        .reg_write    (ctl_e.reg_write),
        .mem_write    (ctl_e.mem_write),
        .pcs          (ctl_e.pcs),
        .branch       (ctl_e.branch),
        .cond_ex      (cond_ex_e),
        .reg_write_g  (ctl_m_next.reg_write),
        .mem_write_g  (ctl_m_next.mem_write),
        .pcs_g        (ctl_m_next.pcs),
        .branch_taken (BranchTakenE)
    );

    assign ctl_m_next.mem_to_reg = ctl_e.mem_to_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_m        <= '0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            pcs_w        <= 1'b0;
        end else begin
            ctl_m        <= ctl_m_next;
            reg_write_w  <= ctl_m.reg_write;
            mem_to_reg_w <= ctl_m.mem_to_reg;
            pcs_w        <= ctl_m.pcs;
        end
    end

    assign ALUSrcE      = ctl_e.alu_src;
    assign ALUControlE  = ALUCTL_W'(ctl_e.alu_ctl);
    assign IgRnE        = ctl_e.ig_rn;
    assign MemtoRegE    = ctl_e.mem_to_reg;
    assign MemWriteM    = ctl_m.mem_write;
    assign RegWriteM    = ctl_m.reg_write;
    assign RegWriteW    = reg_write_w;
    assign MemtoRegW    = mem_to_reg_w;
    assign PCSrcW       = pcs_w;
    assign PCWrPendingF = dec.pcs | ctl_e.pcs | ctl_m.pcs;

`ifdef CTRL_STATS_EN
    logic valid_e;
    logic exec_m;

    // valid_e separates a real instruction from a FlushE/reset bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_e    <= 1'b0;
            exec_m     <= 1'b0;
            RetiredCnt <= '0;
            SquashCnt  <= '0;
        end else begin
            valid_e    <= ~FlushE;
            exec_m     <= valid_e & cond_ex_e;
            RetiredCnt <= RetiredCnt + 32'(exec_m);
            SquashCnt  <= SquashCnt + 32'(FlushE) + 32'(valid_e & ~cond_ex_e);
        end
    end
`endif

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined control path for the 5-stage ARM-subset core; sits beside the datapath and owns all control state.
- Decodes InstrD and carries control bits through D→E→M→W pipeline registers.
- Holds the NZCV flags register and evaluates condition codes in Execute.
- Drives the datapath control inputs plus the signals the hazard unit needs.

Parameters:
- ALUCTL_W, 4, width of the ALU control code (encoding defined in the package).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- InstrD  in  32  Decode-stage instruction.
- ALUFlags  in  4  {N,Z,C,V} from the Execute ALU.
- FlushE  in  1  hazard unit: bubble the E-stage control register.
- RegSrcD  out  2  register-address mux selects.
- ImmSrcD  out  2  extend-unit select.
- ALUSrcE  out  1  SrcB immediate select.
- ALUControlE  out  ALUCTL_W  ALU operation.
- IgRnE  out  1  force SrcA to 0 (MOV).
- BranchTakenE  out  1  B taken; PC takes the ALU result.
- MemWriteM  out  1  data memory write enable.
- RegWriteM  out  1  for the hazard unit.
- MemtoRegE  out  1  load in E, for the load-use stall.
- RegWriteW  out  1  register-file write enable.
- MemtoRegW  out  1  result mux select.
- PCSrcW  out  1  PC written from ResultW.
- PCWrPendingF  out  1  PCSD|PCSE|PCSM, for the fetch stall.

Behaviour:
- Decode (combinational from InstrD), keyed on Op = InstrD[27:26]:
  - 00 DP: ADD, SUB, AND, ORR, MOV, CMP.
  - 01 LDR/STR: immediate offset, add only; U=0 is unsupported and decodes as ADD.
  - 10 B.
  - 11: decodes as NOP, with every write enable 0.
- RegSrcD: DP = 00; STR = 10; B = x1.
- ImmSrcD: DP = 00; memory = 01; B = 10.
- IgRnD is 1 for MOV only.
- CMP: RegWrite = 0; FlagWrite = 11.
- Any DP with S = 1: FlagWrite[1] (NZ) is 1; FlagWrite[0] (CV) is 1 only for ADD, SUB and CMP.
- PCSD = RegWriteD & (InstrD[15:12] == 15).
- D→E register fields: Cond, FlagWrite, RegWrite, MemWrite, MemtoReg, Branch, PCS, ALUSrc, ALUControl, IgRn.
  - FlushE = 1 at the edge loads all-zero fields, which is a NOP bubble.
  - Reset clears the register.
- Execute condition: CondExE is computed from CondE and FlagsQ, the flags value before this cycle's update.
  - Supported codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - 1111 evaluates as never-execute.
- Flags update at the clock edge, each field gated by CondExE:
  - FlagsQ[3:2] ← ALUFlags[3:2] when FlagWriteE[1].
  - FlagsQ[1:0] ← ALUFlags[1:0] when FlagWriteE[0].
  - A flag-setting instruction and a dependent conditional instruction in back-to-back E cycles: the second sees the updated flags. No bypass.
- Gating in E: RegWrite, MemWrite, PCS and Branch are ANDed with CondExE before entering E→M; BranchTakenE = BranchE & CondExE.
- E→M and M→W are plain registers with no stall or flush. Latency D→W is 3 cycles.
- Reset (asynchronous): all pipeline registers and FlagsQ go to 0. Every registered output is 0 during and after reset until instructions propagate.
- Reset mid-operation: in-flight instructions are dropped, with no partial memory or register writes after the reset assertion.
- FlushE in the same cycle as a taken branch in E: the branch still resolves, because it is in E; only the instruction entering E is bubbled.

Optional Feature:
- Macro CTRL_STATS_EN.
- When defined, adds two 32-bit counters as outputs:
  - RetiredCnt: increments when M→W receives an instruction that executed (CondExE was 1 and it was not a bubble).
  - SquashCnt: increments on each FlushE, and on each E cycle with CondExE = 0 and a non-bubble instruction.
  - Both counters wrap modulo 2^32 and reset to 0.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Package ctrl_pkg holds:
  - the ALU control encodings: ADD = 0000, SUB = 0001, AND = 0010, ORR = 0011;
  - the condition-code constants and the Op field constants;
  - the flags-bit indices N = 3, Z = 2, C = 1, V = 0.
- One natural sub-module: cond_unit, which holds FlagsQ and computes CondExE and the gated enables.

Test Plan:
- Reset: reset = 0 with InstrD = ADD R1,R2,R3 → all outputs 0 and FlagsQ = 0; release → RegWriteW = 1 exactly 3 cycles after that instruction sits in D.
- SUBS R0,R0,#1 with R0 = 1, then BEQ → FlagsQ Z = 1 after the SUBS E edge; BranchTakenE = 1 in the BEQ E cycle.
- CMP sets Z = 0, then ADDEQ R4,... → CondExE = 0; RegWriteM = 0 and RegWriteW = 0 for ADDEQ.
- LDR R1,[R2,#4] → MemtoRegE = 1, then MemtoRegW = 1 and RegWriteW = 1; STR → MemWriteM = 1 and RegWriteW = 0.
- FlushE = 1 while an STR is in D → next-cycle E is a bubble: MemWriteM = 0 and no flag change.
- MOV PC,R3 → IgRnE = 1; PCWrPendingF = 1 for 3 cycles (PCSD, then PCSE, then PCSM); PCSrcW = 1 in the W cycle.
